distribution_spi_reader: RTL and testbench
==========================================

Name: distribution_spi_reader

Overview:
- SPI master that fetches one 256-bit distribution word from the external sample-storage device.
- Sits directly upstream of the distribution unit and serves its read-from-storage state.
- The distribution unit pulses `req` with a word address; this block runs a complete SPI read transaction.
- It returns the word on `data_out` with a one-cycle `done` strobe.

Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range is 1 and up.
- CMD_READ, 8'h03: command byte sent first in every transaction.
- ADDR_WIDTH, 8: width of `addr` and of the address field sent on MOSI.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  1  start request; sampled only in IDLE.
- addr  input  ADDR_WIDTH  word address; latched on the edge that accepts `req`.
- spi_miso  input  1  serial data from the storage device.
- spi_sclk  output  1  SPI clock, mode 0 (idles low).
- spi_mosi  output  1  serial data to the storage device.
- spi_cs_n  output  1  chip select, active low.
- busy  output  1  high from request acceptance until `done` has been issued.
- done  output  1  one-cycle strobe; `data_out` is valid from this cycle onward.
- data_out  output  256  last completed word; held until the next completion or reset.

Behaviour:
- Interface: one clock, `clk`. Reset `reset_n` is asynchronous and active-low.
- Reset values (applied asynchronously):
  - spi_sclk=0, spi_cs_n=1, spi_mosi=0
  - busy=0, done=0, data_out=0
  - state=IDLE, all internal counters and shift registers cleared
- Frame definition:
  - BITS = 8 + ADDR_WIDTH + 256; default 272.
  - Frame order: CMD_READ (MSB first), then latched addr (MSB first), then 256 read bits.
  - spi_mosi is 0 throughout the read bits.
- Bit timing, applied to every bit:
  - The bit starts on a clk edge that drives spi_sclk 0 and updates spi_mosi.
  - After CLK_DIV cycles, a clk edge drives spi_sclk 1 and samples spi_miso on that same edge.
  - After a further CLK_DIV cycles, the next bit starts.
  - Each bit therefore lasts 2*CLK_DIV cycles.
- Read data order: the first read bit lands in data_out[255], the last in data_out[0].
- Internal shift register: `data_out` is loaded from it only on entry to DONE and never shows partial data.
- State machine:
  - IDLE: busy=0, spi_cs_n=1, spi_sclk=0. If req=1 on an edge: latch addr, set busy=1 and spi_cs_n=0, drive spi_mosi with CMD_READ[7], go to CS_SETUP.
  - CS_SETUP: hold for CLK_DIV cycles with spi_sclk=0, then go to SHIFT.
  - SHIFT: run BITS bits using the bit timing above. A bit counter runs 0..BITS-1, with no wrap inside a frame. After the high half of the last bit, drive spi_sclk 0 and go to CS_HOLD.
  - CS_HOLD: hold for CLK_DIV cycles with spi_cs_n=0 and spi_sclk=0. Then load data_out from the shift register, set done=1, spi_cs_n=1, busy=0, and go to DONE.
  - DONE: lasts exactly one cycle, during which done=1. `req` is ignored. On the next edge, done=0 and the state returns to IDLE.
  - Illegal state encoding: return to IDLE with the reset-value outputs, except `data_out`, which holds.
- Latency: if `req` is accepted on edge E0, done is high in the cycle after edge E0 + 2*CLK_DIV*(BITS+1).
  - Defaults: E0+2184.
  - CLK_DIV=1: E0+546.
- spi_cs_n deasserts between back-to-back transactions for at least one clk cycle (the DONE cycle).
- `req` or `addr` changes while busy or in DONE are ignored and cannot corrupt the active frame.
- Reset mid-transaction:
  - spi_cs_n goes high immediately (asynchronously).
  - The partial word is discarded and no done is issued.
  - data_out returns to 0.
  - The first req after reset release starts a clean frame.
- A req held high continuously starts a new transaction on the first IDLE edge after DONE.

Test Plan:
- Reset: assert reset_n=0 mid-simulation -> spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, data_out=0 at once, without waiting for clk.
- Single read: req pulse with addr=8'h05; slave model returns 256'h0123456789ABCDEF_FEDCBA9876543210_00112233445566778899AABBCCDDEEFF.
  - MOSI carries 0x03, then 0x05, then 256 zeros.
  - Exactly 272 SCLK rising edges occur.
  - done rises at E0+2184 for exactly one cycle.
  - data_out equals the pattern; busy falls in the same cycle.
- Request while busy: pulse req with addr=8'hAA at cycle E0+100 -> no second frame, address byte on MOSI stays 0x05, exactly one done.
- Back-to-back: keep req=1 through the DONE cycle with addr changed to 8'h06.
  - spi_cs_n is high for exactly one cycle.
  - A second frame starts with MOSI address 0x06; its done is at the first done + 2 + 2184.
- Reset mid-frame: assert reset_n=0 at E0+1000 -> spi_cs_n=1 immediately, no done ever, data_out=0. After release, a req with addr=8'h01 completes normally with correct data.
- CLK_DIV=1 instance:
  - SCLK period is 2 cycles; done arrives at E0+546.
  - Data returned by the slave model with all-ones then alternating 0xA5 bytes matches bit-exactly.

Source files
------------

// File: rtl/distribution_spi_reader_if.sv
// Bundle of the request/response handshake towards the distribution unit and
// the four SPI pins towards the sample-storage device.
//   master : the reader itself (accepts req/addr, drives the SPI pins and
//            returns busy/done/data_out)
//   slave  : the surrounding environment (requester plus storage device)
interface distribution_spi_reader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  req;       // start request
  logic [ADDR_WIDTH-1:0] addr;      // word address
  logic                  busy;      // transaction in progress
  logic                  done;      // one-cycle completion strobe
  logic [255:0]          data_out;  // last completed word
  logic                  spi_sclk;  // SPI clock, mode 0
  logic                  spi_mosi;  // serial data to the device
  logic                  spi_cs_n;  // chip select, active low
  logic                  spi_miso;  // serial data from the device

  modport master (
    input  req, addr, spi_miso,
    output busy, done, data_out, spi_sclk, spi_mosi, spi_cs_n
  );

  modport slave (
    output req, addr, spi_miso,
    input  busy, done, data_out, spi_sclk, spi_mosi, spi_cs_n
  );
endinterface

// File: rtl/distribution_spi_reader.sv
// SPI mode-0 master that fetches one 256-bit distribution word from the
// sample-storage device. A frame is CMD_READ, the latched address, then 256
// read bits; the word is published on data_out together with a done strobe.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : distribution_spi_reader_if.master (req/addr/busy/done/data_out
//             and spi_sclk/spi_mosi/spi_cs_n/spi_miso)
module distribution_spi_reader #(
  parameter int          CLK_DIV    = 4,
  parameter logic [7:0]  CMD_READ   = 8'h03,
  parameter int          ADDR_WIDTH = 8
) (
  input logic                       clk,
  input logic                       reset_n,
  distribution_spi_reader_if.master bus
);
  localparam int HDR   = 8 + ADDR_WIDTH;
  localparam int BITS  = HDR + 256;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    SHIFT    = 3'd2,
    CS_HOLD  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [HDR-1:0]   tx_q, tx_d;      // header bits still to send, MSB next
  logic [255:0]     rx_q, rx_d;      // read bits, first one ends up in [255]
  logic [255:0]     data_q, data_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_last;

  assign div_last = (div_q == DIV_LAST);

  // NOTE: every variable gets a default before the case statement; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        cs_n_d = 1'b1;
        busy_d = 1'b0;
        mosi_d = 1'b0;
        if (bus.req) begin
          // The address is captured here inside the header shifter, so later
          // addr changes cannot reach the frame. Bit 0 goes straight to MOSI.
          tx_d    = {CMD_READ[6:0], bus.addr, 1'b0};
          mosi_d  = CMD_READ[7];
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          rx_d    = '0;
          state_d = CS_SETUP;
        end
      end

      CS_SETUP: begin
        if (div_last) begin
          div_d   = '0;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (!div_last) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            // Rising edge: the device's bit is taken on this same clk edge.
            sclk_d = 1'b1;
            rx_d   = {rx_q[254:0], bus.spi_miso};
          end else if (bit_q == BIT_LAST) begin
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            state_d = CS_HOLD;
          end else begin
            // Header drains to zeros, so MOSI stays low through the read bits.
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
            mosi_d = tx_q[HDR-1];
            tx_d   = {tx_q[HDR-2:0], 1'b0};
          end
        end
      end

      CS_HOLD: begin
        if (div_last) begin
          div_d   = '0;
          data_d  = rx_q;
          done_d  = 1'b1;
          cs_n_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        div_d   = '0;
        bit_d   = '0;
        tx_d    = '0;
        rx_d    = '0;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        cs_n_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  // NOTE: the 256-bit shift and output registers are flops, not RAM, and are
  // cleared on reset so a partial word can never be observed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.spi_sclk = sclk_q;
  assign bus.spi_mosi = mosi_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.data_out = data_q;
endmodule

// File: tb/tb_distribution_spi_reader.sv
// Self-checking bench for distribution_spi_reader: one CLK_DIV=4 instance and
// one CLK_DIV=1 instance, each with a mode-0 storage-device model and a
// scoreboard of expected words.
module tb_distribution_spi_reader;
  localparam int AW   = 8;
  localparam int BITS = 8 + AW + 256;
  localparam int LAT0 = 2 * 4 * (BITS + 1);
  localparam int LAT1 = 2 * 1 * (BITS + 1);

  localparam logic [255:0] P1 =
    256'h0123456789ABCDEF_FEDCBA9876543210_00112233445566778899AABBCCDDEEFF;
  localparam logic [255:0] P2 =
    256'hF0E1D2C3B4A5968778695A4B3C2D1E0F_0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [255:0] P3 =
    256'h80000000000000000000000000000000_00000000000000000000000000000001;
  localparam logic [255:0] P4 = {256{1'b1}};
  localparam logic [255:0] P5 = {32{8'hA5}};

  logic        clk = 1'b0;
  logic        reset_n;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  distribution_spi_reader_if #(.ADDR_WIDTH(AW)) bus0 ();
  distribution_spi_reader_if #(.ADDR_WIDTH(AW)) bus1 ();

  distribution_spi_reader #(.CLK_DIV(4), .CMD_READ(8'h03), .ADDR_WIDTH(AW)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0.master)
  );

  distribution_spi_reader #(.CLK_DIV(1), .CMD_READ(8'h03), .ADDR_WIDTH(AW)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1.master)
  );

  task automatic check(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Storage-device models: a word is taken from the queue on CS fall, MOSI is
  // captured on SCLK rise, read bits are presented on SCLK fall.
  logic [255:0] dq0[$], dq1[$];
  logic [255:0] s0_word, s1_word;
  logic [271:0] s0_rx, s1_rx;
  int           s0_rise, s1_rise;

  always @(negedge bus0.spi_cs_n) begin
    s0_rise = 0;
    s0_rx   = '0;
    s0_word = '0;
    if (dq0.size() != 0) s0_word = dq0.pop_front();
    bus0.spi_miso = 1'b0;
  end
  always @(posedge bus0.spi_sclk) if (bus0.spi_cs_n === 1'b0) begin
    s0_rx = {s0_rx[270:0], bus0.spi_mosi};
    s0_rise++;
  end
  always @(negedge bus0.spi_sclk) if (bus0.spi_cs_n === 1'b0 && s0_rise >= 16 && s0_rise < BITS)
    bus0.spi_miso = s0_word[255 - (s0_rise - 16)];

  always @(negedge bus1.spi_cs_n) begin
    s1_rise = 0;
    s1_rx   = '0;
    s1_word = '0;
    if (dq1.size() != 0) s1_word = dq1.pop_front();
    bus1.spi_miso = 1'b0;
  end
  always @(posedge bus1.spi_sclk) if (bus1.spi_cs_n === 1'b0) begin
    s1_rx = {s1_rx[270:0], bus1.spi_mosi};
    s1_rise++;
  end
  always @(negedge bus1.spi_sclk) if (bus1.spi_cs_n === 1'b0 && s1_rise >= 16 && s1_rise < BITS)
    bus1.spi_miso = s1_word[255 - (s1_rise - 16)];

  // Scoreboards: expected words pushed at request time, popped on done.
  logic [255:0] sb0[$], sb1[$];
  logic [255:0] exp0, exp1;
  int           done0_cnt = 0, done1_cnt = 0;
  int unsigned  done0_cyc, done1_cyc;
  int           rise0_last, rise1_last;
  logic [271:0] rx0_last, rx1_last;

  always @(negedge clk) if (reset_n === 1'b1 && bus0.done === 1'b1) begin
    done0_cnt++;
    done0_cyc  = cyc;
    rise0_last = s0_rise;
    rx0_last   = s0_rx;
    check("sb0_expected", sb0.size() != 0, 1'b1);
    exp0 = '0;
    if (sb0.size() != 0) exp0 = sb0.pop_front();
    check("dut0_data_out", bus0.data_out, exp0);
    check("dut0_busy_at_done", bus0.busy, 1'b0);
  end

  always @(negedge clk) if (reset_n === 1'b1 && bus1.done === 1'b1) begin
    done1_cnt++;
    done1_cyc  = cyc;
    rise1_last = s1_rise;
    rx1_last   = s1_rx;
    check("sb1_expected", sb1.size() != 0, 1'b1);
    exp1 = '0;
    if (sb1.size() != 0) exp1 = sb1.pop_front();
    check("dut1_data_out", bus1.data_out, exp1);
    check("dut1_busy_at_done", bus1.busy, 1'b0);
  end

  task automatic start(input int which, input logic [7:0] a, input logic [255:0] w,
                       input bit expect_done, input bit hold, output int unsigned e0);
    @(negedge clk);
    if (which == 0) begin
      bus0.req = 1'b1;
      bus0.addr = a;
      dq0.push_back(w);
      if (expect_done) sb0.push_back(w);
    end else begin
      bus1.req = 1'b1;
      bus1.addr = a;
      dq1.push_back(w);
      if (expect_done) sb1.push_back(w);
    end
    e0 = cyc + 1;
    @(negedge clk);
    if (!hold) begin
      if (which == 0) bus0.req = 1'b0;
      else bus1.req = 1'b0;
    end
  endtask

  task automatic wait_done(input int which, input int target, input int budget);
    int n = 0;
    while (((which == 0) ? done0_cnt : done1_cnt) < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check($sformatf("wait_done%0d_%0d", which, target),
          (which == 0) ? done0_cnt : done1_cnt, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  int unsigned e0, e0b, d1;
  int          cnt_before;

  initial begin
    reset_n = 1'b0;
    bus0.req = 1'b0; bus0.addr = '0; bus0.spi_miso = 1'b0;
    bus1.req = 1'b0; bus1.addr = '0; bus1.spi_miso = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pins", {bus0.spi_cs_n, bus0.spi_sclk, bus0.spi_mosi, bus0.busy, bus0.done}, 5'b10000);
    check("reset_data_out", bus0.data_out, 256'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read, plus a request while busy that must be ignored.
    start(0, 8'h05, P1, 1'b1, 1'b0, e0);
    check("accept_busy_cs", {bus0.busy, bus0.spi_cs_n}, 2'b10);
    repeat (99) @(negedge clk);
    bus0.req = 1'b1; bus0.addr = 8'hAA;
    @(negedge clk);
    bus0.req = 1'b0;
    wait_done(0, 1, LAT0 + 50);
    check("single_latency", done0_cyc, e0 + LAT0);
    check("single_sclk_edges", rise0_last, BITS);
    check("single_header", rx0_last[271:256], {8'h03, 8'h05});
    check("single_read_mosi", rx0_last[255:0], 256'h0);
    @(negedge clk); #1;
    check("done_one_cycle", bus0.done, 1'b0);
    repeat (40) @(negedge clk);
    check("no_second_frame", {bus0.spi_cs_n, 32'(done0_cnt)}, {1'b1, 32'd1});

    // Back-to-back: req held high through DONE, addr changed mid-frame.
    start(0, 8'h05, P1, 1'b1, 1'b1, e0);
    repeat (5) @(negedge clk);
    bus0.addr = 8'h06;
    sb0.push_back(P2);
    dq0.push_back(P2);
    wait_done(0, 2, LAT0 + 50);
    d1 = done0_cyc;
    check("b2b_first_latency", d1, e0 + LAT0);
    check("b2b_first_header", rx0_last[271:256], {8'h03, 8'h05});
    check("b2b_cs_high_done", bus0.spi_cs_n, 1'b1);
    @(negedge clk); #1;
    check("b2b_cs_high_idle", {bus0.spi_cs_n, bus0.done}, 2'b10);
    @(negedge clk); #1;
    check("b2b_restart", {bus0.spi_cs_n, bus0.busy}, 2'b01);
    bus0.req = 1'b0;
    wait_done(0, 3, LAT0 + 50);
    check("b2b_second_latency", done0_cyc, d1 + 2 + LAT0);
    check("b2b_second_header", rx0_last[271:256], {8'h03, 8'h06});
    repeat (5) @(negedge clk);

    // Reset in the middle of a frame.
    start(0, 8'h33, P2, 1'b0, 1'b0, e0);
    repeat (999) @(negedge clk);
    check("mid_frame_active", bus0.spi_cs_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_pins", {bus0.spi_cs_n, bus0.spi_sclk, bus0.spi_mosi, bus0.busy, bus0.done}, 5'b10000);
    check("async_reset_data", bus0.data_out, 256'h0);
    cnt_before = done0_cnt;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    check("no_done_after_reset", done0_cnt, cnt_before);
    start(0, 8'h01, P3, 1'b1, 1'b0, e0);
    wait_done(0, cnt_before + 1, LAT0 + 50);
    check("post_reset_latency", done0_cyc, e0 + LAT0);
    check("post_reset_header", rx0_last[271:256], {8'h03, 8'h01});

    // CLK_DIV=1 instance.
    start(1, 8'h7E, P4, 1'b1, 1'b0, e0b);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      else begin
        while (cyc < e0b + 2) @(negedge clk);
      end
      check($sformatf("div1_sclk_%0d", k), bus1.spi_sclk, (k % 2 == 0) ? 1'b1 : 1'b0);
    end
    wait_done(1, 1, LAT1 + 50);
    check("div1_latency", done1_cyc, e0b + LAT1);
    check("div1_edges", rise1_last, BITS);
    check("div1_header", rx1_last[271:256], {8'h03, 8'h7E});
    repeat (3) @(negedge clk);
    start(1, 8'hFF, P5, 1'b1, 1'b0, e0b);
    wait_done(1, 2, LAT1 + 50);
    check("div1_a5_latency", done1_cyc, e0b + LAT1);

    repeat (5) @(negedge clk);
    check("sb_drained", {32'(sb0.size()), 32'(sb1.size())}, 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
